ff_stream_processor: RTL
========================

FF_STREAM_PROCESSOR -- requirements
Module: ff_stream_processor

Interface
REQ-001 SHALL have parameter n, default 2: neurons computed in parallel.
REQ-002 SHALL have parameter fi, default 8: total fan-in per neuron.
REQ-003 SHALL have parameter p, default 4: products per neuron per beat; fi divisible by p; beats per group B = fi/p.
REQ-004 SHALL have parameter width, default 16, and int_bits, default 5; frac_bits = width-int_bits-1; 1.0 = 2^frac_bits.
REQ-005 SHALL have ports: clk input 1, clock; reset input 1, synchronous, active-low.
REQ-006 SHALL have ports: act_sel input 2, activation select (0 ReLU, 1 hard-sigmoid, 2 linear, 3 reserved as linear).
REQ-007 SHALL have ports: in_valid input 1; in_ready output 1; flush input 1, abandons partial group.
REQ-008 SHALL have ports: act_in_package input width*n*p, signed activations; wt_package input width*n*p, signed weights; lane k of neuron i at index i*p+k.
REQ-009 SHALL have ports: bias_package input width*n, signed, one per neuron.
REQ-010 SHALL have ports: out_valid output 1; out_ready input 1; act_out_package output width*n; adot_out_package output width*n; sat_flag output n, per-neuron saturation.

Function
REQ-011 SHALL implement states ACCUM, ACT, OUT; in_ready = 1 only in ACCUM.
REQ-012 Beat accepted when in_valid & in_ready; beat counter 0..B-1 increments per accepted beat, wraps to 0 on last beat.
REQ-013 Product = full 2*width signed act*wt, arithmetic right shift by frac_bits, saturated to width bits.
REQ-014 Accumulator width = width+clog2(fi)+1 per neuron, no saturation during accumulation; cleared to beat sum on beat 0.
REQ-015 bias_package SHALL be sampled on the beat with counter 0.
REQ-016 Accepting beat B-1 -> ACT; in ACT, s = acc+bias saturated to width; sat_flag[i] = 1 if clamping occurred.
REQ-017 ReLU: act = max(s,0); adot = 1.0 if s>0 else 0.
REQ-018 Hard-sigmoid: act = clamp((s>>>2)+0.5, 0, 1.0); adot = 0.25 when unclamped, else 0.
REQ-019 Linear: act = s; adot = 1.0.
REQ-020 act_sel SHALL be sampled in ACT; changes elsewhere have no effect on the current group.
REQ-021 ACT -> OUT after 1 cycle; outputs registered; out_valid asserted 2 cycles after last-beat acceptance.
REQ-022 In OUT, outputs SHALL hold stable until out_valid & out_ready, then -> ACCUM (in_ready high next cycle).
REQ-023 flush in ACCUM SHALL zero counter and accumulator; a beat presented in the same cycle SHALL be dropped; flush in ACT/OUT ignored.
REQ-024 B=1 SHALL be supported: every accepted beat completes a group.

Reset
REQ-025 reset low at clk edge SHALL force ACCUM, counter 0, accumulators 0, out_valid 0, act_out/adot_out/sat_flag 0, in_ready 1 the cycle after release; any partial or pending group is discarded.

Structure
REQ-026 Shared package SHALL hold the state enum, act_sel encodings, and fixed-point helpers (saturate, one constant).
REQ-027 One sub-module ff_stream_lane SHALL implement one neuron (products, accumulator, bias add, activation); top holds FSM, counter, handshake.

Verification (n=2, fi=8, p=4, width=16, int_bits=5; 1.0=1024)
REQ-028 Reset held 3 cycles -> out_valid 0, all outputs 0, in_ready 1 after release.
REQ-029 ReLU, acts 1024, wts 512, bias 0, two back-to-back beats -> act_out 4096, adot 1024, sat_flag 0, out_valid exactly 2 cycles after beat 2.
REQ-030 Linear, acts 1024, wts 32767, bias 0 -> act_out 32767, sat_flag 1; wts -32768 -> act_out -32768, sat_flag 1.
REQ-031 Hard-sigmoid: s=0 -> act 512, adot 256; s=4096 -> act 1024, adot 0; s=-4096 -> act 0, adot 0.
REQ-032 out_ready low 5 cycles -> out_valid and data stable, in_ready 0; out_ready high -> handshake, in_ready 1 next cycle.
REQ-033 Beat 0 accepted, then flush, then full group of REQ-029 -> same result as REQ-029; reset mid-group likewise leaves no residue.

Source files
------------

// File: rtl/ff_stream_processor_pkg.sv
// Shared types and fixed-point helpers for the feed-forward stream processor.
package ff_stream_processor_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_ACT   = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    localparam logic [1:0] ACT_RELU = 2'd0;
    localparam logic [1:0] ACT_HSIG = 2'd1;
    localparam logic [1:0] ACT_LIN  = 2'd2;

    // Fixed-point representation of 1.0 for a given number of fraction bits.
    function automatic int fx_one(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    // Clamp a signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/ff_stream_processor_if.sv
// Beat input, parameter and result bus between a producer and the stream processor.
interface ff_stream_processor_if #(
    parameter int n     = 2,
    parameter int p     = 4,
    parameter int width = 16
);
    logic [1:0]             act_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic                   flush;
    logic [width*n*p-1:0]   act_in_package;
    logic [width*n*p-1:0]   wt_package;
    logic [width*n-1:0]     bias_package;
    logic                   out_valid;
    logic                   out_ready;
    logic [width*n-1:0]     act_out_package;
    logic [width*n-1:0]     adot_out_package;
    logic [n-1:0]           sat_flag;

    modport master (
        output act_sel, in_valid, flush, act_in_package, wt_package, bias_package, out_ready,
        input  in_ready, out_valid, act_out_package, adot_out_package, sat_flag
    );

    modport slave (
        input  act_sel, in_valid, flush, act_in_package, wt_package, bias_package, out_ready,
        output in_ready, out_valid, act_out_package, adot_out_package, sat_flag
    );
endinterface

// File: rtl/ff_stream_lane.sv
// One neuron: saturated fixed-point products, wide accumulator, bias add and activation.
module ff_stream_lane
    import ff_stream_processor_pkg::*;
#(
    parameter int fi       = 8,
    parameter int p        = 4,
    parameter int width    = 16,
    parameter int int_bits = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_en_i,
    input  logic                 first_i,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [1:0]           act_sel_i,
    input  logic [width*p-1:0]   act_vec_i,
    input  logic [width*p-1:0]   wt_vec_i,
    input  logic [width-1:0]     bias_i,
    output logic [width-1:0]     act_o,
    output logic [width-1:0]     adot_o,
    output logic                 sat_o
);
    localparam int FRAC = width - int_bits - 1;
    localparam int ACCW = width + $clog2(fi) + 1;
    localparam logic signed [width-1:0] ONE     = width'(fx_one(FRAC));
    localparam logic signed [width-1:0] HALF    = ONE >>> 1;
    localparam logic signed [width-1:0] QUARTER = ONE >>> 2;

    logic signed [width-1:0] prod [p];
    logic signed [ACCW-1:0]  beat_sum;
    logic signed [ACCW-1:0]  acc_q;
    logic signed [width-1:0] bias_q;
    logic signed [ACCW:0]    s_full;
    logic signed [width-1:0] s_c;
    logic signed [width-1:0] hs;
    logic                    sat_c;
    logic signed [width-1:0] act_d, adot_d;
    logic [width-1:0]        act_q, adot_q;
    logic                    sat_q;

    genvar gi;
    for (gi = 0; gi < p; gi++) begin : g_prod
        logic signed [2*width-1:0] full;
        logic signed [2*width-1:0] shifted;
        assign full    = $signed(act_vec_i[gi*width +: width]) * $signed(wt_vec_i[gi*width +: width]);
        assign shifted = full >>> FRAC;
        assign prod[gi] = width'(sat_s(64'(shifted), width));
    end

    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < p; k++)
            beat_sum = beat_sum + ACCW'(prod[k]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q  <= '0;
            bias_q <= '0;
        end else if (clr_i) begin
            acc_q  <= '0;
        end else if (acc_en_i) begin
            acc_q <= first_i ? beat_sum : acc_q + beat_sum;
            if (first_i)
                bias_q <= $signed(bias_i);
        end
    end

    // Accumulator is wide enough to never wrap; clamping happens once, after the bias add.
    assign s_full = (ACCW+1)'(acc_q) + (ACCW+1)'(bias_q);
    assign s_c    = width'(sat_s(64'(s_full), width));
    assign sat_c  = ((ACCW+1)'(s_c) != s_full);
    assign hs     = (s_c >>> 2) + HALF;

    always_comb begin
        act_d  = s_c;
        adot_d = ONE;
        case (act_sel_i)
            ACT_RELU: begin
                act_d  = (s_c > 0) ? s_c : '0;
                adot_d = (s_c > 0) ? ONE : '0;
            end
            ACT_HSIG: begin
                if (hs < 0) begin
                    act_d  = '0;
                    adot_d = '0;
                end else if (hs > ONE) begin
                    act_d  = ONE;
                    adot_d = '0;
                end else begin
                    act_d  = hs;
                    adot_d = QUARTER;
                end
            end
            default: begin
                act_d  = s_c;
                adot_d = ONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            act_q  <= '0;
            adot_q <= '0;
            sat_q  <= 1'b0;
        end else if (load_i) begin
            act_q  <= act_d;
            adot_q <= adot_d;
            sat_q  <= sat_c;
        end
    end

    assign act_o  = act_q;
    assign adot_o = adot_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/ff_stream_processor.sv
// Streams fan-in beats into n parallel neuron lanes and hands back one result per group.
module ff_stream_processor
    import ff_stream_processor_pkg::*;
#(
    parameter int n        = 2,
    parameter int fi       = 8,
    parameter int p        = 4,
    parameter int width    = 16,
    parameter int int_bits = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    ff_stream_processor_if.slave   bus
);
    localparam int B  = fi / p;
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           in_ready_c, accept, clr, last_beat;
    logic [width*n-1:0] act_out_w, adot_out_w;
    logic [n-1:0]       sat_w;

    // A flushing cycle drops any beat presented alongside it.
    assign in_ready_c = (state_q == ST_ACCUM);
    assign clr        = in_ready_c && bus.flush;
    assign accept     = in_ready_c && bus.in_valid && !bus.flush;
    assign last_beat  = (cnt_q == CW'(B - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACCUM: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (accept) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = ST_ACT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_ACT:  state_d = ST_OUT;
            ST_OUT:  if (bus.out_ready) state_d = ST_ACCUM;
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    genvar gi;
    for (gi = 0; gi < n; gi++) begin : g_lane
        ff_stream_lane #(
            .fi       (fi),
            .p        (p),
            .width    (width),
            .int_bits (int_bits)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .acc_en_i  (accept),
            .first_i   (cnt_q == '0),
            .clr_i     (clr),
            .load_i    (state_q == ST_ACT),
            .act_sel_i (bus.act_sel),
            .act_vec_i (bus.act_in_package[gi*width*p +: width*p]),
            .wt_vec_i  (bus.wt_package[gi*width*p +: width*p]),
            .bias_i    (bus.bias_package[gi*width +: width]),
            .act_o     (act_out_w[gi*width +: width]),
            .adot_o    (adot_out_w[gi*width +: width]),
            .sat_o     (sat_w[gi])
        );
    end

    assign bus.in_ready         = in_ready_c;
    assign bus.out_valid        = (state_q == ST_OUT);
    assign bus.act_out_package  = act_out_w;
    assign bus.adot_out_package = adot_out_w;
    assign bus.sat_flag         = sat_w;

endmodule
